tile_grid_renderer: RTL

Parametrised tile-map renderer for the VGA object chain: it holds a COLS x ROWS grid of tile types in internal RAM and converts each scanned pixel coordinate into a drawing request and an 8-bit RGB value. It supports:
- runtime tile updates from game logic, such as collecting a gift or breaking a floor tile;
- an automatic whole-map clear after reset or on command;
- a blinking gift tile.

Its outputs feed the priority mux alongside the other drawing objects.

---
 rtl/tile_grid_pkg.sv | 22 ++
 rtl/tile_grid_if.sv | 27 ++
 rtl/tile_grid_ram.sv | 26 ++
 rtl/tile_grid_renderer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tile_grid_pkg.sv
// Shared tile types, sweep states and colour encodings (RRRGGGBB) for the tile-grid renderer.
package tile_grid_pkg;

    typedef enum logic [1:0] {
        TILE_BACKGROUND = 2'd0,
        TILE_FLOOR      = 2'd1,
        TILE_GIFT       = 2'd2,
        TILE_WALL       = 2'd3
    } tile_t;

    typedef enum logic {
        ST_CLR_SWEEP = 1'b0,
        ST_RUN       = 1'b1
    } sweep_state_t;

    localparam logic [7:0] TRANSPARENT = 8'hFF;
    localparam logic [7:0] FLOOR       = 8'hA1;
    localparam logic [7:0] GIFT        = 8'hBB;
    localparam logic [7:0] GIFT_ALT    = 8'hE0;
    localparam logic [7:0] WALL        = 8'h49;

endpackage

// File: rtl/tile_grid_if.sv
// Scan, tile-update and drawing-output signals between game/VGA logic and the tile-grid renderer.
interface tile_grid_if #(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 7
);
    logic [10:0]               pixelX;
    logic [10:0]               pixelY;
    logic                      startOfFrame;
    logic                      wrEn;
    logic [$clog2(COLS)-1:0]   wrCol;
    logic [$clog2(ROWS)-1:0]   wrRow;
    logic [1:0]                wrType;
    logic                      clearReq;
    logic                      busy;
    logic                      drawingRequest;
    logic [7:0]                RGBout;

    modport master (
        output pixelX, pixelY, startOfFrame, wrEn, wrCol, wrRow, wrType, clearReq,
        input  busy, drawingRequest, RGBout
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, wrEn, wrCol, wrRow, wrType, clearReq,
        output busy, drawingRequest, RGBout
    );
endinterface

// File: rtl/tile_grid_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port returning old data on collision.
module tile_grid_ram #(
    parameter int unsigned DEPTH = 70,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Both updates are non-blocking, so a same-address read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/tile_grid_renderer.sv
// Tile-map renderer: map RAM, clear-sweep FSM and 2-stage pixel pipeline.
// Gift-box blinking is built only when TILE_GRID_ANIM_EN is defined.
module tile_grid_renderer
    import tile_grid_pkg::*;
#(
    parameter int unsigned COLS        = 10,
    parameter int unsigned ROWS        = 7,
    parameter int unsigned TILE_W      = 64,
    parameter int unsigned TILE_H      = 64,
    parameter int unsigned ANIM_FRAMES = 16
) (
    input  logic       clk,
    input  logic       resetN,
    tile_grid_if.slave bus
);
    localparam int unsigned DEPTH = COLS * ROWS;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OXW   = $clog2(TILE_W);
    localparam int unsigned OYW   = $clog2(TILE_H);

    sweep_state_t   r_state, w_state_nxt;
    logic [AW-1:0]  r_ptr, w_ptr_nxt;
    logic           w_busy;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_CLR_SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (r_state == ST_CLR_SWEEP) begin
            if (bus.clearReq) begin
                w_ptr_nxt = '0;
            end else if (r_ptr == AW'(DEPTH - 1)) begin
                w_state_nxt = ST_RUN;
                w_ptr_nxt   = '0;
            end else begin
                w_ptr_nxt = r_ptr + 1'b1;
            end
        end else if (bus.clearReq) begin
            w_state_nxt = ST_CLR_SWEEP;
            w_ptr_nxt   = '0;
        end
    end

    assign w_busy = (r_state == ST_CLR_SWEEP);

    logic           w_wr_in_range;
    logic           w_we;
    logic [AW-1:0]  w_waddr;
    logic [1:0]     w_wdata;

    assign w_wr_in_range = (32'(bus.wrCol) < COLS) && (32'(bus.wrRow) < ROWS);

    // The sweep owns the write port while busy; game writes in that window are dropped.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = TILE_BACKGROUND;
        if (w_busy) begin
            w_we    = 1'b1;
            w_waddr = r_ptr;
        end else if (bus.wrEn && w_wr_in_range) begin
            w_we    = 1'b1;
            w_waddr = AW'(32'(bus.wrRow) * COLS + 32'(bus.wrCol));
            w_wdata = bus.wrType;
        end
    end

    logic [10:0]     w_col, w_row;
    logic            w_in_grid;
    logic [AW-1:0]   w_raddr;
    logic [1:0]      w_tile_raw;
    logic [OXW-1:0]  r_offX;
    logic [OYW-1:0]  r_offY;
    logic            r_valid;

    assign w_col     = bus.pixelX >> OXW;
    assign w_row     = bus.pixelY >> OYW;
    assign w_in_grid = (32'(w_col) < COLS) && (32'(w_row) < ROWS);
    assign w_raddr   = w_in_grid ? AW'(32'(w_row) * COLS + 32'(w_col)) : '0;

    tile_grid_ram #(
        .DEPTH (DEPTH),
        .WIDTH (2),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_tile_raw)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_offX  <= '0;
            r_offY  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_offX  <= bus.pixelX[OXW-1:0];
            r_offY  <= bus.pixelY[OYW-1:0];
            r_valid <= w_in_grid && !w_busy;
        end
    end

    logic w_phase;

`ifdef TILE_GRID_ANIM_EN
    localparam int unsigned FCW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    logic [FCW-1:0] r_frame;
    logic           r_phase;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (bus.startOfFrame) begin
            if (r_frame == FCW'(ANIM_FRAMES - 1)) begin
                r_frame <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

    assign w_phase = r_phase;
`else
    logic w_unused_sof;
    assign w_unused_sof = bus.startOfFrame;
    assign w_phase      = 1'b0;
`endif

    tile_t       w_tile;
    logic        w_bar, w_box;
    logic [7:0]  w_rgb, r_rgb;

    assign w_tile = tile_t'(w_tile_raw);
    assign w_bar  = (r_offY >= OYW'(TILE_H * 3 / 4)) && (r_offY < OYW'(TILE_H * 15 / 16)) &&
                    (r_offX >= OXW'(TILE_W / 8))     && (r_offX < OXW'(TILE_W * 7 / 8));
    assign w_box  = (r_offX >= OXW'(TILE_W / 4))     && (r_offX < OXW'(TILE_W * 3 / 4)) &&
                    (r_offY >= OYW'(TILE_H / 4))     && (r_offY < OYW'(TILE_H * 3 / 4));

    always_comb begin
        w_rgb = TRANSPARENT;
        if (r_valid) begin
            case (w_tile)
                TILE_FLOOR: if (w_bar) w_rgb = FLOOR;
                TILE_GIFT: begin
                    if (w_bar)      w_rgb = FLOOR;
                    else if (w_box) w_rgb = w_phase ? GIFT_ALT : GIFT;
                end
                TILE_WALL:  w_rgb = WALL;
                default:    w_rgb = TRANSPARENT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rgb <= TRANSPARENT;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign bus.busy           = w_busy;
    assign bus.RGBout         = r_rgb;
    assign bus.drawingRequest = (r_rgb != TRANSPARENT);
endmodule
